// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: hazard/stall sequencer for a 5-stage pipeline (load-use, branch flush, memory wait with timeout trap)
module pipeline_stall_controller #(
    parameter int REG_BITS    = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [REG_BITS-1:0] id_src1,
    input  logic [REG_BITS-1:0] id_src2,
    input  logic                id_src1_used,
    input  logic                id_src2_used,
    input  logic [REG_BITS-1:0] ex_dest,
    input  logic                ex_mem_read,
    input  logic                branch_taken,
    input  logic                mem_req,
    input  logic                mem_ready,
    output logic                pc_stall,
    output logic                if_id_stall,
    output logic                if_id_flush,
    output logic                id_ex_stall,
    output logic                id_ex_flush,
    output logic                ex_mem_stall,
    output logic                mem_wb_bubble,
    output logic                mem_timeout,
    output logic [CNT_W-1:0]    stall_count
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, TRAP} state_t;
    state_t            state_q, state_d;
    logic [7:0]        wait_cnt_q, wait_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;
    logic              lu, mb, freeze, flush, lu_stall;
    assign lu = ex_mem_read && (ex_dest != '0) &&
                ((id_src1_used && id_src1 == ex_dest) || (id_src2_used && id_src2 == ex_dest));
    assign mb = mem_req && !mem_ready;
    // next state and Mealy controls; freeze holds everything upstream of MEM/WB
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        freeze     = 1'b0;
        flush      = 1'b0;
        lu_stall   = 1'b0;
        case (state_q)
            RUN: begin
                if (mb) begin
                    freeze     = 1'b1;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end else begin
                    flush    = branch_taken;
                    lu_stall = !branch_taken && lu;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = 8'd0;
                    flush      = branch_taken;
                    lu_stall   = !branch_taken && lu;
                end else begin
                    freeze = 1'b1;
                    if (wait_cnt_q == 8'(MEM_TIMEOUT)) state_d = TRAP;
                    else wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            TRAP:    freeze = 1'b1;
            default: state_d = RUN;
        endcase
        if (rst) begin
            state_d    = RUN;
            wait_cnt_d = 8'd0;
            freeze     = 1'b0;
            flush      = 1'b0;
            lu_stall   = 1'b0;
        end
        mem_timeout_d = !rst && (mem_timeout_q || state_d == TRAP);
        stall_count_d = rst ? '0 : (pc_stall && !(&stall_count_q)) ? stall_count_q + 1'b1 : stall_count_q;
    end
    assign pc_stall      = freeze || lu_stall;
    assign if_id_stall   = freeze || lu_stall;
    assign if_id_flush   = flush;
    assign id_ex_stall   = freeze;
    assign id_ex_flush   = flush || lu_stall;
    assign ex_mem_stall  = freeze;
    assign mem_wb_bubble = freeze;
    assign mem_timeout   = mem_timeout_q;
    assign stall_count   = stall_count_q;
    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            wait_cnt_q    <= 8'd0;
            mem_timeout_q <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_count_q <= stall_count_d;
        end
    end
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb_pipeline_stall_controller: directed + randomized check against a behavioural model
module tb_pipeline_stall_controller;
    localparam int TO = 4;
    localparam int CW = 4;
    logic clk = 1'b0, rst;
    logic [3:0] id_src1, id_src2, ex_dest;
    logic id_src1_used, id_src2_used, ex_mem_read, branch_taken, mem_req, mem_ready;
    logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_bubble, mem_timeout;
    logic [CW-1:0] stall_count;
    int n_tests = 0, n_fail = 0;
    bit chk_en = 0;
    int cnt = 0, waits = 0;
    bit waiting = 0, trapped = 0, tflag = 0;

    pipeline_stall_controller #(.REG_BITS(4), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
        .id_src1_used(id_src1_used), .id_src2_used(id_src2_used), .ex_dest(ex_dest),
        .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .mem_req(mem_req),
        .mem_ready(mem_ready), .pc_stall(pc_stall), .if_id_stall(if_id_stall),
        .if_id_flush(if_id_flush), .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
        .ex_mem_stall(ex_mem_stall), .mem_wb_bubble(mem_wb_bubble),
        .mem_timeout(mem_timeout), .stall_count(stall_count));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input int s1, input int s2, input bit u1, input bit u2,
                         input int d, input bit mr, input bit br, input bit rq, input bit rd);
        rst = r; id_src1 = 4'(s1); id_src2 = 4'(s2); id_src1_used = u1; id_src2_used = u2;
        ex_dest = 4'(d); ex_mem_read = mr; branch_taken = br; mem_req = rq; mem_ready = rd;
    endtask

    // check one cycle against the model, then advance the model across the clock edge
    task automatic step();
        bit lu, fr, fl, ls;
        logic [6:0] e, g;
        #1;
        lu = ex_mem_read && ex_dest != 0 &&
             ((id_src1_used && id_src1 == ex_dest) || (id_src2_used && id_src2 == ex_dest));
        fr = !rst && (trapped || (waiting ? !mem_ready : (mem_req && !mem_ready)));
        fl = !rst && !fr && branch_taken;
        ls = !rst && !fr && !branch_taken && lu;
        e = {fr | ls, fr | ls, fl, fr, fl | ls, fr, fr};
        g = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_bubble};
        if (chk_en) begin
            check("ctrl", 32'(g), 32'(e));
            check("timeout", 32'(mem_timeout), 32'(tflag));
            check("count", 32'(stall_count), 32'(cnt));
        end
        @(posedge clk);
        if (rst) begin
            cnt = 0; waits = 0; waiting = 0; trapped = 0; tflag = 0;
        end else begin
            if (e[6] && cnt < (1 << CW) - 1) cnt++;
            if (!trapped) begin
                if (waiting) begin
                    if (mem_ready) waiting = 0;
                    else if (waits == TO) begin trapped = 1; tflag = 1; end
                    else waits++;
                end else if (mem_req && !mem_ready) begin
                    waiting = 1; waits = 1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step(); end
    endtask

    task automatic reset1();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    endtask

    initial begin
        reset1();
        chk_en = 1;
        reset1();
        check("rst_cnt", 32'(stall_count), 0);
        drive(0, 3, 0, 1, 0, 3, 1, 0, 0, 0); step();
        idle(1);
        check("lu_cnt", 32'(stall_count), 1);
        drive(0, 0, 0, 1, 0, 0, 1, 0, 0, 0); step();
        drive(0, 1, 5, 1, 0, 5, 1, 0, 0, 0); step();
        drive(0, 3, 0, 1, 0, 3, 1, 1, 0, 0); step();
        reset1();
        for (int i = 0; i < 4; i++) begin drive(0, 0, 0, 0, 0, 0, 0, 0, 1, i == 3); step(); end
        check("mw_cnt", 32'(stall_count), 3);
        reset1();
        for (int i = 0; i < 8; i++) begin drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); step(); end
        check("trap_flag", 32'(mem_timeout), 1);
        check("trap_pc", 32'(pc_stall), 1);
        reset1();
        check("trap_rst", 32'(mem_timeout), 0);
        for (int i = 0; i < 20; i++) begin drive(0, 2, 0, 1, 0, 2, 1, 0, 0, 0); step(); end
        check("sat_cnt", 32'(stall_count), 15);
        reset1();
        for (int i = 0; i < 3000; i++) begin
            bit slow = (i / 300) % 2 == 1;
            drive($urandom_range(99) < 3, $urandom_range(3), $urandom_range(3),
                  $urandom_range(1), $urandom_range(1), $urandom_range(3),
                  $urandom_range(1), $urandom_range(99) < 20, $urandom_range(99) < 30,
                  slow ? $urandom_range(99) < 10 : $urandom_range(1) == 1);
            step();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
